// File: rtl/mips_pkg.sv
// Shared MIPS32 front-end definitions: word width, primary opcodes and fetch
// sequencer state encoding.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // Byte offset of a conditional branch: sign-extended immediate times four.
    function automatic logic [WORD_W-1:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Next-PC selection for the fetch sequencer: jump region target, taken branch
// displacement or sequential fall-through.
module mips_next_pc
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] pc_plus4,
    input  logic [WORD_W-1:0] instr,
    input  logic              branch,
    input  logic              jump,
    input  logic              alu_zero,
    output logic [WORD_W-1:0] next_pc,
    output logic              taken
);

    // The opcode field plays no part in target selection; the decoder already
    // folded it into branch/jump.
    logic unused_opcode;
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        next_pc = pc_plus4;
        // jal raises both branch and jump, so jump is tested first. An unknown
        // control bit fails the if-test and falls through to pc_plus4.
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
        end
        taken = (next_pc != pc_plus4);
    end

endmodule

// File: rtl/mips_fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ready handshake
// and holds each instruction for decode until the datapath accepts it.
module mips_fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter bit                ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic [5:0]        op,
    output logic              instr_valid,
    input  logic              instr_accept,
    input  logic              branch,
    input  logic              jump,
    input  logic              alu_zero,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              branch_taken,
    output logic              misalign_err
);

    fetch_state_t      state;
    logic [WORD_W-1:0] next_pc;
    logic              taken;

    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign pc_plus4  = pc + 32'd4;

    mips_next_pc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .branch   (branch),
        .jump     (jump),
        .alu_zero (alu_zero),
        .next_pc  (next_pc),
        .taken    (taken)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RESET;
            pc           <= RESET_PC;
            instr        <= '0;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b0;
            branch_taken <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            unique case (state)
                ST_RESET: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Control inputs matter only in the accept cycle.
                    if (instr_accept) begin
                        pc           <= next_pc;
                        instr_valid  <= 1'b0;
                        imem_req     <= 1'b1;
                        branch_taken <= taken;
                        state        <= ST_FETCH;
                        if (ALIGN_CHECK && (next_pc[1:0] != 2'b00)) begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= ST_RESET;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    a_req_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_req && instr_valid));

    a_fetch_wait: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_FETCH && !imem_ready) |=> ($stable(pc) && imem_req));

    a_hold_wait: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_HOLD && !instr_accept) |=> ($stable(instr) && $stable(pc) && instr_valid));

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Scoreboard bench for mips_fetch_sequencer: a driver plays memory and datapath,
// a monitor compares every handshake against a reference PC model.
module tb_mips_fetch_sequencer;
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ADDI_W   = 32'h2008_0005;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ready, instr_valid, instr_accept;
    logic        branch, jump, alu_zero, branch_taken, misalign_err;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
    logic [5:0]  op;

    always #5 clk = ~clk;

    mips_fetch_sequencer #(.RESET_PC(RESET_PC), .ALIGN_CHECK(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .op           (op),
        .instr_valid  (instr_valid),
        .instr_accept (instr_accept),
        .branch       (branch),
        .jump         (jump),
        .alu_zero     (alu_zero),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .branch_taken (branch_taken),
        .misalign_err (misalign_err)
    );

    typedef struct { logic [31:0] pc; logic [31:0] word; } acc_t;
    typedef struct { logic [31:0] next_pc; logic taken; } post_t;

    logic [31:0] exp_fetch[$];
    acc_t        exp_acc[$];
    post_t       exp_post[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Architectural next-PC rule, written from the ISA definition.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input bit b, input bit j, input bit z);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ({6'b0, w[25:0]} * 32'd4);
        if (b && z) return p4 + 32'(int'($signed(w[15:0])) * 4);
        return p4;
    endfunction

    // One fetch/decode/accept round trip: d memory wait cycles, a accept-withheld cycles.
    task automatic run_instr(input logic [31:0] w, input bit b, input bit j, input bit z,
                             input int d, input int a);
        int          k;
        logic [31:0] nxt;
        exp_acc.push_back('{model_pc, w});
        k = 0;
        while (!imem_req && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("req_latency", 32'(k), 32'd0);
        for (int c = 0; c < d; c++) begin
            instr_accept = 1'($urandom_range(0, 1));
            imem_rdata   = $urandom;
            @(posedge clk); #1;
        end
        instr_accept = 1'b0;
        imem_ready   = 1'b1;
        imem_rdata   = w;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("valid_latency", {31'b0, instr_valid}, 32'd1);
        for (int c = 0; c < a; c++) begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            branch     = 1'($urandom_range(0, 1));
            jump       = 1'($urandom_range(0, 1));
            alu_zero   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        imem_ready = 1'b0;
        nxt = model_next(model_pc, w, b, j, z);
        exp_post.push_back('{nxt, (nxt != model_pc + 32'd4)});
        branch       = b;
        jump         = j;
        alu_zero     = z;
        instr_accept = 1'b1;
        @(posedge clk); #1;
        instr_accept = 1'b0;
        branch       = 1'($urandom_range(0, 1));
        jump         = 1'($urandom_range(0, 1));
        alu_zero     = 1'($urandom_range(0, 1));
        model_pc     = nxt;
        exp_fetch.push_back(model_pc);
    endtask

    // Walk the PC into a 256 MB region by jumping to each region's last word.
    task automatic walk_to_region(input logic [3:0] r);
        for (int n = 0; n < 40 && model_pc[31:28] != r; n++) begin
            if (model_pc[27:0] == 28'hFFF_FFFC) run_instr(ADDI_W, 0, 0, 0, 0, 0);
            else run_instr({OP_J, 26'h3FF_FFFF}, 0, 1, 0, 0, 0);
        end
        check("walk_region", {28'b0, model_pc[31:28]}, {28'b0, r});
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin
        bit    post_pending;
        acc_t  ea;
        post_t ep;
        post_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                post_pending = 1'b0;
            end else begin
                if (post_pending) begin
                    post_pending = 1'b0;
                    if (exp_post.size() == 0) begin
                        note_fail("post_queue_empty");
                    end else begin
                        ep = exp_post.pop_front();
                        check("next_pc", pc, ep.next_pc);
                        check("branch_taken", {31'b0, branch_taken}, {31'b0, ep.taken});
                        check("misalign_err", {31'b0, misalign_err}, 32'd0);
                    end
                end else begin
                    check("taken_idle", {31'b0, branch_taken}, 32'd0);
                end
                if (imem_req) begin
                    if (exp_fetch.size() == 0) begin
                        note_fail("unexpected_fetch");
                    end else begin
                        check("imem_addr", imem_addr, exp_fetch[0]);
                        if (imem_ready) void'(exp_fetch.pop_front());
                    end
                end
                if (instr_valid) begin
                    if (exp_acc.size() == 0) begin
                        note_fail("unexpected_valid");
                    end else begin
                        ea = exp_acc[0];
                        check("instr", instr, ea.word);
                        check("op", {26'b0, op}, {26'b0, ea.word[31:26]});
                        check("pc", pc, ea.pc);
                        check("pc_plus4", pc_plus4, ea.pc + 32'd4);
                        if (instr_accept) begin
                            check("ctrl_known", {31'b0, $isunknown({branch, jump, alu_zero})}, 32'd0);
                            void'(exp_acc.pop_front());
                            post_pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Driver: directed scenarios first, then randomized traffic, then reset abort.
    initial begin
        logic [31:0] w;
        bit          b, j, z;
        imem_ready   = 1'b0;
        imem_rdata   = '0;
        instr_accept = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        alu_zero     = 1'b0;
        model_pc     = RESET_PC;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, RESET_PC);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_taken", {31'b0, branch_taken}, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
        exp_fetch.push_back(RESET_PC);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        check("no_req_in_reset_state", {31'b0, imem_req}, 32'd0);
        @(posedge clk); #1;

        run_instr(ADDI_W, 0, 0, 0, 0, 0);
        check("addi_pc", pc, 32'h4);
        run_instr({OP_J, 26'h4}, 0, 1, 0, 0, 0);
        run_instr(32'h1000_FFFE, 1, 0, 1, 0, 0);
        check("beq_taken_pc", pc, 32'h0C);
        run_instr({OP_J, 26'h4}, 0, 1, 0, 0, 0);
        run_instr(32'h1000_FFFE, 1, 0, 0, 0, 0);
        check("beq_not_taken_pc", pc, 32'h14);
        run_instr(ADDI_W, 0, 0, 0, 5, 3);

        walk_to_region(4'h4);
        run_instr({OP_J, 26'h8}, 0, 1, 0, 0, 0);
        check("at_jal_pc", pc, 32'h4000_0020);
        run_instr(32'h0C00_0100, 1, 1, 1, 0, 1);
        check("jal_pc", pc, 32'h4000_0400);

        walk_to_region(4'hF);
        run_instr({OP_J, 26'h3FF_FFFF}, 0, 1, 0, 0, 0);
        check("at_wrap_pc", pc, 32'hFFFF_FFFC);
        run_instr(ADDI_W, 0, 0, 0, 1, 0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_misalign", {31'b0, misalign_err}, 32'd0);

        for (int n = 0; n < 150; n++) begin
            w = $urandom;
            j = ($urandom_range(0, 7) == 0);
            b = ($urandom_range(0, 2) == 0);
            z = 1'($urandom_range(0, 1));
            run_instr(w, b, j, z, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset lands while a fetch is being answered; the word must not be taken.
        check("pre_reset_req", {31'b0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n      = 1'b0;
        exp_fetch.delete();
        exp_acc.delete();
        exp_post.delete();
        #1;
        check("abort_valid", {31'b0, instr_valid}, 32'd0);
        check("abort_pc", pc, RESET_PC);
        check("abort_req", {31'b0, imem_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_instr", instr, 32'd0);
        check("abort_valid_hold", {31'b0, instr_valid}, 32'd0);
        imem_ready = 1'b0;
        model_pc   = RESET_PC;
        exp_fetch.push_back(RESET_PC);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) begin
            run_instr($urandom, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end
        repeat (3) @(posedge clk);
        #1;
        check("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
        check("post_queue_drained", 32'(exp_post.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_fetch_sequencer.md
Name: mips_fetch_sequencer

Overview:
- Instruction-fetch front end for the single-cycle MIPS32 datapath; the producing end of the opcode/branch/jump interface.
- Holds the PC, fetches words from instruction memory over a req/ready handshake, and presents the instruction and `op` field to the main control decoder.
- On accept, consumes the decoder's `branch`/`jump` outputs and the ALU zero flag to select the next PC.
- Sits between instruction memory and the control/datapath stage.

Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- `ALIGN_CHECK`, 1, when 1 a misaligned computed PC raises `misalign_err`.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `imem_req`  out  1  fetch request; held until `imem_ready`
- `imem_addr`  out  32  fetch address (= current PC)
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle
- `imem_rdata`  in  32  fetched instruction word
- `instr`  out  32  registered instruction presented to decode
- `op`  out  6  `instr[31:26]`
- `instr_valid`  out  1  `instr` is valid
- `instr_accept`  in  1  datapath consumes `instr` this cycle
- `branch`  in  1  from control decoder
- `jump`  in  1  from control decoder
- `alu_zero`  in  1  ALU zero flag for the current instruction
- `pc`  out  32  PC of the current instruction
- `pc_plus4`  out  32  `pc`+4; link value for jal
- `branch_taken`  out  1  one-cycle pulse when branch/jump redirects
- `misalign_err`  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async, `rst_n`=0):
  - state=RESET, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, `branch_taken`=0, `misalign_err`=0.
  - Assertion in any state aborts an outstanding fetch; a `imem_ready` that arrives during reset is ignored.
- States: RESET, FETCH, HOLD.
  - RESET: the first clock after `rst_n` rises goes to FETCH. No request is issued in the RESET cycle.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
    - On `imem_ready`=1: latch `imem_rdata` into `instr`, set `instr_valid`=1, drop `imem_req`, go to HOLD.
    - Otherwise stay in FETCH with `pc` stable. Wait is unbounded.
  - HOLD: `instr_valid`=1, `instr` and `pc` stable.
    - On `instr_accept`=1: update `pc` to next_pc, clear `instr_valid`, go to FETCH.
    - `branch`/`jump`/`alu_zero` are sampled only in that accept cycle.
- Minimum latency:
  - Reset release → first `imem_req` is 1 cycle.
  - `imem_ready` → `instr_valid` is 1 cycle.
  - accept → next `imem_req` is 1 cycle.
  - Throughput is 1 instruction per 2 cycles when memory is zero-wait.
- next_pc (mod 2^32, wrap silently):
  - `jump`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`. Jump has priority over branch, because jal asserts both.
  - else `branch`=1 and `alu_zero`=1: `pc_plus4 + (sign_extend(instr[15:0]) << 2)`.
  - else: `pc_plus4`.
  - `branch` with `alu_zero`=0 falls through to `pc_plus4`.
- `branch_taken`: registered pulse, high in the cycle after an accept whose next_pc ≠ `pc_plus4`.
- `pc_plus4`: combinational `pc`+4; 32'hFFFF_FFFC+4 = 0.
- `misalign_err`: with `ALIGN_CHECK`=1, set if next_pc[1:0]≠0. This can only arise from a misaligned `RESET_PC`, since computed targets are always aligned.
- Simultaneous events: `instr_accept` outside HOLD is ignored. `imem_ready` outside FETCH is ignored.
- X-handling: `branch`/`jump` that are X in the accept cycle are treated as 0 (fall-through); the bench flags this as an error.

Decomposition:
- Shared package `mips_pkg`:
  - opcode constants `OP_RTYPE`=6'h00, `OP_J`=6'h02, `OP_JAL`=6'h03, `OP_BEQ`=6'h04, `OP_BNE`=6'h05, `OP_ADDI`=6'h08, `OP_LW`=6'h23, `OP_SW`=6'h2b
  - fetch state encoding
  - `WORD_W`=32
- One sub-module, `mips_next_pc`: combinational target computation (inputs `pc_plus4`, `instr`, `branch`, `jump`, `alu_zero`; outputs `next_pc`, `taken`).

Test Plan:
- Reset sequencing: reset with `RESET_PC`=0, release, zero-wait memory returning 32'h2008_0005 (addi). Expect `imem_addr`=0 one cycle after release, `op`=6'h08, and after accept `pc`=4 with `branch_taken`=0.
- Branch taken: at `pc`=32'h10, `instr`=32'h1000_FFFE (beq, offset −2), `branch`=1, `alu_zero`=1. Expect next `pc`=32'h0C and a `branch_taken` pulse. Repeat with `alu_zero`=0: expect `pc`=32'h14.
- jal priority: at `pc`=32'h4000_0020, `instr`=32'h0C00_0100, `branch`=1, `jump`=1. Expect `pc`=32'h4000_0400 and `pc_plus4` was 32'h4000_0024 at accept.
- Memory wait / back-pressure: `imem_ready` delayed 5 cycles, then `instr_accept` withheld 3 cycles. Expect `imem_req`/`imem_addr` stable for 5 cycles, `instr` stable for 3, and no duplicate fetch.
- Reset mid-operation: assert `rst_n`=0 during FETCH while `imem_ready`=1. Expect `instr_valid`=0 and `pc`=`RESET_PC` immediately, with no latch of `imem_rdata`.
- Wrap-around: `pc`=32'hFFFF_FFFC, no branch or jump. Expect next `pc`=0 and `misalign_err`=0.
